fb_pixel_writer: RTL and testbench
==================================

// Module: fb_pixel_writer
// PURPOSE
// - Write-side front end of the framebuffer BRAM (1-cycle read/write, active-low enable, active-high write).
// - Accepts rasterizer pixels (x, y, colour) on a valid/ready handshake, clips them to the screen,
//   converts to a linear address and issues one BRAM write per accepted pixel.
// - Also owns full-screen clear: on request it sweeps every address with a clear colour.
// PARAMETERS
// - FB_W        64   framebuffer width in pixels
// - FB_H        64   framebuffer height in pixels
// - ADDR_WIDTH  12   BRAM address width; FB_W*FB_H <= 2**ADDR_WIDTH
// - DATA_WIDTH  24   pixel colour width (RGB888)
// - COORD_WIDTH 8    width of the x and y inputs (unsigned)
// PORTS
// - clk          in   1            single clock
// - rst          in   1            asynchronous, active-high reset
// - pix_valid    in   1            pixel offered
// - pix_ready    out  1            pixel accepted when pix_valid & pix_ready
// - pix_x        in   COORD_WIDTH  pixel column
// - pix_y        in   COORD_WIDTH  pixel row
// - pix_color    in   DATA_WIDTH   pixel colour
// - clear_req    in   1            1-cycle pulse: start a full clear
// - clear_color  in   DATA_WIDTH   colour used for clear; sampled on the clear_req cycle
// - clear_done   out  1            1-cycle pulse after the last clear write
// - busy         out  1            high while clearing
// - clip_cnt     out  16           dropped-pixel count, saturates at 16'hFFFF
// - bram_cen     out  1            BRAM enable, active low
// - bram_wen     out  1            BRAM write enable
// - bram_addr    out  ADDR_WIDTH   BRAM address
// - bram_din     out  DATA_WIDTH   BRAM write data
// BEHAVIOUR
// - Reset: state=IDLE, bram_cen=1, bram_wen=0, bram_addr=0, bram_din=0, clear_done=0, busy=0, clip_cnt=0.
// - All bram_* outputs are registered. An accepted pixel appears on the BRAM port the next cycle with
//   bram_cen=0 and bram_wen=1 for exactly 1 cycle. With no write, bram_cen=1 and bram_wen=0.
// - The pipeline is fully throughput-capable: 1 pixel per clock while in IDLE.
// - States:
//   - IDLE:  pix_ready = !clear_req (combinational). On clear_req -> CLEAR with counter=0,
//            and the clear colour is latched.
//   - CLEAR: pix_ready=0, busy=1. Each cycle writes addr=counter and data=latched colour, then increments.
//            After writing FB_W*FB_H-1: go to IDLE and pulse clear_done on the following cycle,
//            aligned with busy falling.
// - clear_req has priority over a simultaneous pix_valid; that pixel is not accepted and stays offered.
// - clear_req asserted during CLEAR is ignored; the clear is not restarted.
// - Address: bram_addr = pix_y*FB_W + pix_x, computed at ADDR_WIDTH width.
//   FB_W must be a power of two, so the multiply reduces to a shift.
// - Clipping:
//   - A pixel with pix_x>=FB_W or pix_y>=FB_H is still accepted (handshake completes) but generates no write.
//   - Each such pixel increments clip_cnt by 1; it holds at 16'hFFFF once saturated.
// - Reset mid-clear: the sweep is abandoned, state=IDLE, and no clear_done pulse is generated.
// - A write already on the BRAM port completes in the cycle it is presented; nothing is buffered.
// STRUCTURE
// - Shared package fb_pkg holds:
//   - FB_W, FB_H, ADDR_WIDTH, DATA_WIDTH, and FB_PIXELS = FB_W*FB_H
//   - the state encoding constants (IDLE=1'b0, CLEAR=1'b1)
// - One sub-module, fb_addr_calc: combinational x/y -> address plus the in_bounds flag.
// - The FSM, clear counter, clip counter and output registers live in this module.
// TESTING (bench instantiates fb_pixel_writer + bram, default parameters)
// - Reset then pixel (x=3,y=2,colour=24'hFF0000):
//   -> next cycle cen=0, wen=1, addr=131, din=24'hFF0000; BRAM read of 131 returns 24'hFF0000.
// - 64 back-to-back valid pixels with valid held high:
//   -> pix_ready stays 1, 64 consecutive write cycles, addresses match y*64+x.
// - Pixel x=64,y=0 then x=0,y=70:
//   -> both handshakes complete, no BRAM write occurs, clip_cnt=2.
// - clear_req with clear_color=24'h0000FF:
//   -> busy for 4096 cycles, addrs 0..4095 written once each, clear_done pulses once,
//      every word reads 24'h0000FF.
// - clear_req and pix_valid in the same cycle:
//   -> pixel not accepted; it is written after the clear completes, over the clear colour.
// - Assert rst at clear count 1000:
//   -> outputs return to their reset values asynchronously, no clear_done pulse; IDLE accepts pixels after release.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, bus widths and the writer FSM state encoding.
package fb_pkg;
    localparam int FB_W        = 64;
    localparam int FB_H        = 64;
    localparam int ADDR_WIDTH  = 12;
    localparam int DATA_WIDTH  = 24;
    localparam int COORD_WIDTH = 8;
    localparam int FB_PIXELS   = FB_W * FB_H;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;
endpackage

// File: rtl/fb_addr_calc.sv
// Combinational (x, y) -> linear framebuffer address, plus the on-screen flag.
// FB_W is a power of two, so the row multiply is a constant shift.
module fb_addr_calc #(
    parameter int FB_W        = fb_pkg::FB_W,
    parameter int FB_H        = fb_pkg::FB_H,
    parameter int ADDR_WIDTH  = fb_pkg::ADDR_WIDTH,
    parameter int COORD_WIDTH = fb_pkg::COORD_WIDTH
) (
    input  logic [COORD_WIDTH-1:0] x,
    input  logic [COORD_WIDTH-1:0] y,
    output logic [ADDR_WIDTH-1:0]  addr,
    output logic                   in_bounds
);
    localparam int XSH = $clog2(FB_W);

    assign addr      = (ADDR_WIDTH'(y) << XSH) + ADDR_WIDTH'(x);
    assign in_bounds = (32'(x) < FB_W) && (32'(y) < FB_H);
endmodule

// File: rtl/fb_pixel_writer.sv
// Framebuffer write front end: clipped pixel writes at one per clock, plus a full-screen clear sweep.
// All BRAM port signals are registered; a write is presented for exactly one cycle.
module fb_pixel_writer #(
    parameter int FB_W        = fb_pkg::FB_W,
    parameter int FB_H        = fb_pkg::FB_H,
    parameter int ADDR_WIDTH  = fb_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH  = fb_pkg::DATA_WIDTH,
    parameter int COORD_WIDTH = fb_pkg::COORD_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pix_valid,
    output logic                   pix_ready,
    input  logic [COORD_WIDTH-1:0] pix_x,
    input  logic [COORD_WIDTH-1:0] pix_y,
    input  logic [DATA_WIDTH-1:0]  pix_color,
    input  logic                   clear_req,
    input  logic [DATA_WIDTH-1:0]  clear_color,
    output logic                   clear_done,
    output logic                   busy,
    output logic [15:0]            clip_cnt,
    output logic                   bram_cen,
    output logic                   bram_wen,
    output logic [ADDR_WIDTH-1:0]  bram_addr,
    output logic [DATA_WIDTH-1:0]  bram_din
);
    import fb_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_W * FB_H - 1);

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [DATA_WIDTH-1:0] clr_color;
    logic [ADDR_WIDTH-1:0] pix_addr;
    logic                  pix_in;

    fb_addr_calc #(
        .FB_W        (FB_W),
        .FB_H        (FB_H),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .COORD_WIDTH (COORD_WIDTH)
    ) u_addr (
        .x         (pix_x),
        .y         (pix_y),
        .addr      (pix_addr),
        .in_bounds (pix_in)
    );

    // A clear request wins the cycle, so a coincident pixel stays offered.
    assign pix_ready = (state == IDLE) && !clear_req;
    assign busy      = (state == CLEAR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            clr_cnt    <= '0;
            clr_color  <= '0;
            clip_cnt   <= '0;
            clear_done <= 1'b0;
            bram_cen   <= 1'b1;
            bram_wen   <= 1'b0;
            bram_addr  <= '0;
            bram_din   <= '0;
        end else begin
            bram_cen   <= 1'b1;
            bram_wen   <= 1'b0;
            clear_done <= 1'b0;
            if (state == CLEAR) begin
                bram_cen  <= 1'b0;
                bram_wen  <= 1'b1;
                bram_addr <= clr_cnt;
                bram_din  <= clr_color;
                if (clr_cnt == LAST_ADDR) begin
                    state      <= IDLE;
                    clear_done <= 1'b1;
                end else begin
                    clr_cnt <= clr_cnt + 1'b1;
                end
            end else if (clear_req) begin
                state     <= CLEAR;
                clr_cnt   <= '0;
                clr_color <= clear_color;
            end else if (pix_valid) begin
                if (pix_in) begin
                    bram_cen  <= 1'b0;
                    bram_wen  <= 1'b1;
                    bram_addr <= pix_addr;
                    bram_din  <= pix_color;
                end else if (clip_cnt != 16'hFFFF) begin
                    clip_cnt <= clip_cnt + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fb_pixel_writer.sv
// Randomized bench for fb_pixel_writer with a BRAM model and a framebuffer-level reference.
module tb_fb_pixel_writer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_valid, pix_ready;
    logic [7:0]  pix_x, pix_y;
    logic [23:0] pix_color;
    logic        clear_req;
    logic [23:0] clear_color;
    logic        clear_done, busy;
    logic [15:0] clip_cnt;
    logic        bram_cen, bram_wen;
    logic [11:0] bram_addr;
    logic [23:0] bram_din;

    fb_pixel_writer dut (
        .clk         (clk),
        .rst         (rst),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_color   (pix_color),
        .clear_req   (clear_req),
        .clear_color (clear_color),
        .clear_done  (clear_done),
        .busy        (busy),
        .clip_cnt    (clip_cnt),
        .bram_cen    (bram_cen),
        .bram_wen    (bram_wen),
        .bram_addr   (bram_addr),
        .bram_din    (bram_din)
    );

    always #5 clk = ~clk;

    logic [23:0] mem    [4096];
    logic [23:0] exp_fb [4096];
    int          wcnt   [4096];
    int          wq[$];
    int          wcyc[$];
    int          cyc, busy_cycles, done_cnt, align_err, exp_clip;
    logic        prev_busy = 1'b0;
    int          n_chk = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // BRAM model plus event counters, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (!bram_cen && bram_wen) begin
            mem[bram_addr] = bram_din;
            wcnt[bram_addr]++;
            wq.push_back(int'(bram_addr));
            wcyc.push_back(cyc);
        end
        if (busy) busy_cycles++;
        if (clear_done) begin
            done_cnt++;
            if (busy || !prev_busy) align_err++;
        end
        prev_busy = busy;
    end

    task automatic model_pixel(input int x, input int y, input logic [23:0] c);
        if (x < 64 && y < 64) exp_fb[y * 64 + x] = c;
        else if (exp_clip < 65535) exp_clip++;
    endtask

    task automatic model_clear(input logic [23:0] c);
        for (int i = 0; i < 4096; i++) exp_fb[i] = c;
    endtask

    task automatic offer(input int x, input int y, input logic [23:0] c, output bit acc);
        @(negedge clk);
        pix_valid = 1'b1;
        pix_x     = 8'(x);
        pix_y     = 8'(y);
        pix_color = c;
        #1;
        acc = pix_ready;
        if (acc) model_pixel(x, y, c);
    endtask

    task automatic idle();
        @(negedge clk);
        pix_valid = 1'b0;
        clear_req = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_logs();
        wq.delete();
        wcyc.delete();
        for (int i = 0; i < 4096; i++) wcnt[i] = 0;
    endtask

    function automatic int mem_diff();
        int d = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== exp_fb[i]) d++;
        return d;
    endfunction

    task automatic wait_done(input int target, input string tag);
        int n = 0;
        while (done_cnt < target && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(done_cnt >= target), 32'd1);
    endtask

    initial begin
        bit acc;
        int x, y, bad, notready, exp_q[$];
        logic [23:0] c;

        pix_valid = 0; pix_x = 0; pix_y = 0; pix_color = 0;
        clear_req = 0; clear_color = 0;
        exp_clip = 0;
        for (int i = 0; i < 4096; i++) begin mem[i] = '0; exp_fb[i] = '0; wcnt[i] = 0; end

        #12;
        chk("rst_cen", 32'(bram_cen), 32'd1);
        chk("rst_wen", 32'(bram_wen), 32'd0);
        chk("rst_addr", 32'(bram_addr), 32'd0);
        chk("rst_din", 32'(bram_din), 32'd0);
        chk("rst_done", 32'(clear_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_clip", 32'(clip_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single pixel, one-cycle write latency
        offer(3, 2, 24'hFF0000, acc);
        chk("t1_ready", 32'(acc), 32'd1);
        @(posedge clk); #1;
        chk("t1_cen", 32'(bram_cen), 32'd0);
        chk("t1_wen", 32'(bram_wen), 32'd1);
        chk("t1_addr", 32'(bram_addr), 32'(2 * 64 + 3));
        chk("t1_din", 32'(bram_din), 32'hFF0000);
        idle();
        tick(1);
        chk("t1_cen_after", 32'(bram_cen), 32'd1);
        chk("t1_read", 32'(mem[2 * 64 + 3]), 32'hFF0000);

        // 64 back-to-back pixels
        tick(2);
        reset_logs();
        notready = 0;
        for (int i = 0; i < 64; i++) begin
            x = $urandom_range(0, 63);
            y = $urandom_range(0, 63);
            offer(x, y, 24'($urandom), acc);
            if (!acc) notready++;
            exp_q.push_back(y * 64 + x);
        end
        idle();
        tick(3);
        chk("b2b_notready", 32'(notready), 32'd0);
        chk("b2b_nwrites", 32'(wq.size()), 32'd64);
        bad = 0;
        for (int i = 0; i < 64; i++) if (i >= wq.size() || wq[i] != exp_q[i]) bad++;
        chk("b2b_addrs", 32'(bad), 32'd0);
        if (wcyc.size() == 64) chk("b2b_consecutive", 32'(wcyc[63] - wcyc[0]), 32'd63);
        else chk("b2b_consecutive", 32'(wcyc.size()), 32'd64);
        chk("b2b_mem", 32'(mem_diff()), 32'd0);

        // Off-screen pixels complete the handshake but never write
        reset_logs();
        offer(64, 0, 24'h111111, acc);
        chk("clip1_ready", 32'(acc), 32'd1);
        offer(0, 70, 24'h222222, acc);
        chk("clip2_ready", 32'(acc), 32'd1);
        idle();
        tick(3);
        chk("clip_nwrites", 32'(wq.size()), 32'd0);
        chk("clip_cnt2", 32'(clip_cnt), 32'(exp_clip));

        // Random mix with gaps, some off-screen
        notready = 0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
                tick($urandom_range(0, 2));
            end
            x = $urandom_range(0, 79);
            y = $urandom_range(0, 79);
            c = 24'($urandom);
            offer(x, y, c, acc);
            if (!acc) notready++;
        end
        idle();
        tick(3);
        chk("rnd_notready", 32'(notready), 32'd0);
        chk("rnd_clip", 32'(clip_cnt), 32'(exp_clip));
        chk("rnd_mem", 32'(mem_diff()), 32'd0);

        // Full clear; a second request mid-sweep must be ignored
        reset_logs();
        busy_cycles = 0; done_cnt = 0; align_err = 0;
        @(negedge clk);
        clear_req = 1'b1;
        clear_color = 24'h0000FF;
        #1;
        chk("clr_ready_low", 32'(pix_ready), 32'd0);
        model_clear(24'h0000FF);
        @(negedge clk);
        clear_req = 1'b0;
        tick(100);
        @(negedge clk);
        clear_req = 1'b1;
        clear_color = 24'h123456;
        @(negedge clk);
        clear_req = 1'b0;
        wait_done(1, "clr_done_timeout");
        tick(5);
        chk("clr_busy_cycles", 32'(busy_cycles), 32'd4096);
        chk("clr_done_pulses", 32'(done_cnt), 32'd1);
        chk("clr_done_align", 32'(align_err), 32'd0);
        bad = 0;
        for (int i = 0; i < 4096; i++) if (wcnt[i] != 1) bad++;
        chk("clr_once_each", 32'(bad), 32'd0);
        chk("clr_mem", 32'(mem_diff()), 32'd0);

        // Clear and pixel together: pixel waits and lands over the clear colour
        done_cnt = 0;
        @(negedge clk);
        clear_req = 1'b1;
        clear_color = 24'h00FF00;
        pix_valid = 1'b1; pix_x = 8'd5; pix_y = 8'd5; pix_color = 24'hABCDEF;
        #1;
        chk("sim_ready_low", 32'(pix_ready), 32'd0);
        model_clear(24'h00FF00);
        @(negedge clk);
        clear_req = 1'b0;
        x = 0;
        #1;
        while (!pix_ready && x < 6000) begin
            @(negedge clk); #1;
            x++;
        end
        chk("sim_accept_timeout", 32'(pix_ready), 32'd1);
        model_pixel(5, 5, 24'hABCDEF);
        idle();
        wait_done(1, "sim_done_timeout");
        tick(3);
        chk("sim_pixel", 32'(mem[5 * 64 + 5]), 32'hABCDEF);
        chk("sim_mem", 32'(mem_diff()), 32'd0);
        chk("sim_done_pulses", 32'(done_cnt), 32'd1);

        // Reset during a clear sweep
        done_cnt = 0;
        @(negedge clk);
        clear_req = 1'b1;
        clear_color = 24'h777777;
        @(negedge clk);
        clear_req = 1'b0;
        tick(999);
        #2 rst = 1'b1;
        #1;
        exp_clip = 0;
        chk("arst_cen", 32'(bram_cen), 32'd1);
        chk("arst_wen", 32'(bram_wen), 32'd0);
        chk("arst_addr", 32'(bram_addr), 32'd0);
        chk("arst_din", 32'(bram_din), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(clear_done), 32'd0);
        chk("arst_clip", 32'(clip_cnt), 32'(exp_clip));
        tick(3);
        rst = 1'b0;
        tick(3300);
        chk("arst_no_done", 32'(done_cnt), 32'd0);
        chk("arst_busy_after", 32'(busy), 32'd0);
        offer(10, 20, 24'hC0FFEE, acc);
        chk("arst_ready", 32'(acc), 32'd1);
        @(posedge clk); #1;
        chk("arst_wr_cen", 32'(bram_cen), 32'd0);
        chk("arst_wr_addr", 32'(bram_addr), 32'(20 * 64 + 10));
        chk("arst_wr_din", 32'(bram_din), 32'hC0FFEE);
        idle();
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
